// File: rtl/sieve_stream.sv
// Sieve of Eratosthenes over an external single-port blockram; streams primes
// in ascending order on a valid/ready port and reports the final prime count.
module sieve_stream #(
  parameter int ADDR = 8,
  parameter int DATA = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in__start,
  input  logic [ADDR-1:0] in__limit,
  output logic [ADDR-1:0] out__addr,
  output logic            out__wr,
  output logic [DATA-1:0] out__dout,
  input  logic [DATA-1:0] in__din,
  output logic [ADDR-1:0] out__prime,
  output logic            out__prime_valid,
  input  logic            in__prime_ready,
  output logic            out__rdy,
  output logic            out__done,
  output logic [ADDR-1:0] out__count
);

  // state   | meaning
  // IDLE    | waiting for start
  // CLEAR   | zeroing flags 0..L, one write per cycle
  // CHK_RD  | p*p bound test, read flag of p
  // CHK_EV  | p composite? skip : start marking
  // MARK    | write composite flag at m, m += p
  // SCAN_RD | read flag of s
  // SCAN_EV | s prime? emit : advance
  // EMIT    | hold prime/valid until consumer takes it
  // DONE    | run complete, count valid, can restart
  typedef enum logic [3:0] {
    IDLE, CLEAR, CHK_RD, CHK_EV, MARK, SCAN_RD, SCAN_EV, EMIT, DONE
  } state_t;

  state_t          state_q, state_d;
  logic [ADDR-1:0] limit_q, limit_d;
  logic [ADDR-1:0] a_q, a_d;
  logic [ADDR-1:0] p_q, p_d;
  logic [ADDR:0]   m_q, m_d;
  logic [ADDR-1:0] s_q, s_d;
  logic [ADDR-1:0] prime_q, prime_d;
  logic            valid_q, valid_d;
  logic [ADDR-1:0] count_q, count_d;
  logic            done_q, done_d;

  logic [ADDR-1:0]   mem_addr;
  logic              mem_wr;
  logic              mem_bit;
  logic [2*ADDR-1:0] p_sq;
  logic [2*ADDR-1:0] limit_wide;
  logic [ADDR:0]     m_next;
  logic              unused_din;

  // The bound test runs at double width so p*p never aliases below L.
  assign p_sq       = {{ADDR{1'b0}}, p_q} * {{ADDR{1'b0}}, p_q};
  assign limit_wide = {{ADDR{1'b0}}, limit_q};
  assign m_next     = m_q + {1'b0, p_q};
  assign unused_din = ^in__din[DATA-1:1];

  always_comb begin
    state_d  = state_q;
    limit_d  = limit_q;
    a_d      = a_q;
    p_d      = p_q;
    m_d      = m_q;
    s_d      = s_q;
    prime_d  = prime_q;
    valid_d  = valid_q;
    count_d  = count_q;
    done_d   = done_q;
    mem_addr = '0;
    mem_wr   = 1'b0;
    mem_bit  = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (in__start) begin
          limit_d = in__limit;
          count_d = '0;
          done_d  = 1'b0;
          a_d     = '0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        mem_addr = a_q;
        mem_wr   = 1'b1;
        if (a_q == limit_q) begin
          if (limit_q < ADDR'(2)) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            p_d     = ADDR'(2);
            state_d = CHK_RD;
          end
        end else begin
          a_d = a_q + 1'b1;
        end
      end
      CHK_RD: begin
        if (p_sq > limit_wide) begin
          s_d     = ADDR'(2);
          state_d = SCAN_RD;
        end else begin
          mem_addr = p_q;
          state_d  = CHK_EV;
        end
      end
      CHK_EV: begin
        if (in__din[0]) begin
          p_d     = p_q + 1'b1;
          state_d = CHK_RD;
        end else begin
          m_d     = p_sq[ADDR:0];
          state_d = MARK;
        end
      end
      MARK: begin
        mem_addr = m_q[ADDR-1:0];
        mem_wr   = 1'b1;
        mem_bit  = 1'b1;
        m_d      = m_next;
        // Exit on the next multiple so every MARK cycle carries a write.
        if (m_next > {1'b0, limit_q}) begin
          p_d     = p_q + 1'b1;
          state_d = CHK_RD;
        end
      end
      SCAN_RD: begin
        mem_addr = s_q;
        state_d  = SCAN_EV;
      end
      SCAN_EV, EMIT: begin
        if ((state_q == SCAN_EV) && !in__din[0]) begin
          prime_d = s_q;
          valid_d = 1'b1;
          state_d = EMIT;
        end else if ((state_q == SCAN_EV) || in__prime_ready) begin
          if (state_q == EMIT) begin
            count_d = count_q + 1'b1;
            valid_d = 1'b0;
          end
          if (s_q == limit_q) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            s_d     = s_q + 1'b1;
            state_d = SCAN_RD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      limit_q <= '0;
      a_q     <= '0;
      p_q     <= '0;
      m_q     <= '0;
      s_q     <= '0;
      prime_q <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      limit_q <= limit_d;
      a_q     <= a_d;
      p_q     <= p_d;
      m_q     <= m_d;
      s_q     <= s_d;
      prime_q <= prime_d;
      valid_q <= valid_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign out__addr        = mem_addr;
  assign out__wr          = mem_wr;
  assign out__dout        = {{(DATA-1){1'b0}}, mem_bit};
  assign out__prime       = prime_q;
  assign out__prime_valid = valid_q;
  assign out__rdy         = (state_q == IDLE) || (state_q == DONE);
  assign out__done        = done_q;
  assign out__count       = count_q;

endmodule
